oled_init_ctrl: RTL and testbench
=================================

# oled_init_ctrl

Power-up sequencer for an SSD1306-class 128x64 OLED controller. Drives the panel's hardware reset pin, then streams a fixed command table to a downstream byte writer (SPI/I2C serializer) through a one-byte `ena_write`/`write_done` handshake. Asserts `init_done` when finished, handing the writer over to the display-refresh logic. Sits between the top-level clock/reset and the shared OLED byte writer.

## Interface
Parameters:
- `RST_LOW_CYCLES`, default 1000: clock cycles `oled_rst` is held low (10 us at 100 MHz).
- `RST_WAIT_CYCLES`, default 1000: clock cycles waited after `oled_rst` rises before the first command.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: synchronous, active-high reset (1 = reset), sampled on `clk`.
- `write_done`, input, 1: writer-ready level; 1 means the previous byte is finished and the writer is idle.
- `oled_rst`, output, 1: panel reset pin, active low.
- `oled_dc`, output, 1: 0 = command byte, 1 = display-data byte; valid with `data`.
- `data`, output, 8: byte to transmit.
- `ena_write`, output, 1: one-cycle request pulse to the writer.
- `init_done`, output, 1: sticky flag, sequence complete.

All outputs are registered.

## Operation
- States: RST_LOW, RST_WAIT, SEND, GAP, WAIT, DONE.
- Reset values: `oled_rst`=0, `oled_dc`=0, `data`=8'h00, `ena_write`=0, `init_done`=0, state=RST_LOW, counters=0, byte index=0.
- RST_LOW: `oled_rst`=0 for `RST_LOW_CYCLES` cycles, then `oled_rst`=1 and go to RST_WAIT.
- RST_WAIT: count `RST_WAIT_CYCLES` cycles, then go to SEND.
- SEND (1 cycle): `ena_write`=1; `data` = table[index]; `oled_dc` = 0 for commands, 1 for display data.
- GAP (1 cycle): `ena_write`=0 and `write_done` is ignored, giving the writer time to drop its ready level.
- WAIT: stay while `write_done`=0. When `write_done`=1, increment the index, then go to SEND, or to DONE after the last byte.
- DONE: `init_done`=1; `ena_write` stays 0; `oled_rst` stays 1; `data`/`oled_dc` hold their last values. Exit only via reset.
- Command table (25 bytes, in order, all `oled_dc`=0):
  - AE
  - D5 80
  - A8 3F
  - D3 00
  - 40
  - 8D 14
  - 20 02
  - A1
  - C8
  - DA 12
  - 81 CF
  - D9 F1
  - DB 40
  - A4
  - A6
  - AF
- `data` and `oled_dc` stay stable from a SEND cycle until the next SEND cycle.
- Reset asserted in any state returns every output to its reset value on the next edge; the sequence restarts from RST_LOW.

## Timing
- Cycle 1 is the first rising edge with `rst_n`=0 after reset.
- `oled_rst` rises at the end of cycle `RST_LOW_CYCLES`.
- Byte k (0-based) is requested when `write_done` is held at 1:
  - `ena_write` is high during cycle RST_LOW_CYCLES+RST_WAIT_CYCLES+1+3k.
  - Minimum 3 cycles per byte.
  - Each cycle `write_done`=0 in WAIT adds one cycle.
- `init_done` rises in cycle RST_LOW_CYCLES+RST_WAIT_CYCLES+1+3N, where N is the total byte count. With defaults and the macro undefined, that is cycle 2076.

## Configuration
- Macro `OLED_INIT_CLEAR_EN`: when defined, the GDDRAM clear sequence is compiled in and appended after AF.
  - For each page p=0..7: commands B0+p, 00, 10 (`oled_dc`=0), then 128 bytes 8'h00 (`oled_dc`=1).
  - Adds 1048 bytes, so N=1073 and `init_done` rises at cycle 5220 with defaults.
- Undefined: the clear sequence is absent, N=25.

## Test plan
- Reset held, then released with `write_done` tied 1 and defaults: `oled_rst`=0 for cycles 1..1000 and 1 from cycle 1001; no `ena_write` before cycle 2001.
- Same run: 25 single-cycle `ena_write` pulses, 3 cycles apart, starting at cycle 2001. Bytes AE,D5,80,...,A6,AF in order, all with `oled_dc`=0. `init_done`=1 from cycle 2076 and stays 1.
- Hold `write_done` low for 10 cycles after the 3rd pulse: the 4th pulse is delayed by exactly 10 cycles, and `data` stays 8'h80 throughout.
- Assert reset during byte 12: all outputs return to reset values next edge; the sequence restarts and completes exactly as in scenario 2.
- With `OLED_INIT_CLEAR_EN` defined:
  - After AF the bench sees B0,00,10, then 128 bytes 00 with `oled_dc`=1, and so on through page B7.
  - `init_done` rises at cycle 5220.

Source files
------------

// File: rtl/oled_init_ctrl.sv
// Power-up sequencer for an SSD1306-class OLED: pulses the panel reset, then streams the init table to the byte writer.
// Define OLED_INIT_CLEAR_EN to append a full GDDRAM clear (8 pages x {B0+p, 00, 10, 128 x 00}) after the table.
module oled_init_ctrl #(
   parameter int RST_LOW_CYCLES  = 1000,
   parameter int RST_WAIT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       write_done,
   output logic       oled_rst,
   output logic       oled_dc,
   output logic [7:0] data,
   output logic       ena_write,
   output logic       init_done
);

   localparam int unsigned CMD_BYTES = 25;
   localparam int unsigned PAGE_LEN  = 131;
`ifdef OLED_INIT_CLEAR_EN
   localparam int unsigned CLR_BYTES = 8 * PAGE_LEN;
`else
   localparam int unsigned CLR_BYTES = 0;
`endif
   localparam int unsigned TOTAL   = CMD_BYTES + CLR_BYTES;
   localparam int unsigned IDX_W   = $clog2(TOTAL);
   localparam int unsigned CNT_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [7:0] CMD_TABLE [CMD_BYTES] = '{
      8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
      8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
      8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
   };

   typedef enum logic [2:0] {RST_LOW, RST_WAIT, SEND, GAP, WAIT, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;

   // Returns {dc, byte} for a sequence position.
   function automatic logic [8:0] entry(input logic [IDX_W-1:0] pos);
      logic [8:0] e;
`ifdef OLED_INIT_CLEAR_EN
      logic [IDX_W-1:0] j;
      logic [IDX_W-1:0] pg;
      logic [IDX_W-1:0] off;
`endif
      e = {1'b0, CMD_TABLE[pos[4:0]]};
`ifdef OLED_INIT_CLEAR_EN
      if (pos >= IDX_W'(CMD_BYTES)) begin
         j   = pos - IDX_W'(CMD_BYTES);
         pg  = j / IDX_W'(PAGE_LEN);
         off = j % IDX_W'(PAGE_LEN);
         if (off == IDX_W'(0))      e = {1'b0, 8'hB0 + pg[7:0]};
         else if (off == IDX_W'(1)) e = {1'b0, 8'h00};
         else if (off == IDX_W'(2)) e = {1'b0, 8'h10};
         else                       e = {1'b1, 8'h00};
      end
`endif
      return e;
   endfunction

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= RST_LOW;
         cnt       <= '0;
         idx       <= '0;
         oled_rst  <= 1'b0;
         oled_dc   <= 1'b0;
         data      <= '0;
         ena_write <= 1'b0;
         init_done <= 1'b0;
      end else begin
         ena_write <= 1'b0;
         case (state)
            // Reset edge loads cnt=0, so the full count keeps the pin low for RST_LOW_CYCLES post-reset cycles.
            RST_LOW: begin
               if (cnt == CNT_W'(RST_LOW_CYCLES)) begin
                  cnt      <= '0;
                  oled_rst <= 1'b1;
                  state    <= RST_WAIT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RST_WAIT: begin
               if (cnt == CNT_W'(RST_WAIT_CYCLES - 1)) begin
                  cnt               <= '0;
                  idx               <= '0;
                  ena_write         <= 1'b1;
                  {oled_dc, data}   <= entry('0);
                  state             <= SEND;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SEND: state <= GAP;
            GAP:  state <= WAIT;
            WAIT: begin
               if (write_done) begin
                  if (idx == IDX_W'(TOTAL - 1)) begin
                     init_done <= 1'b1;
                     state     <= DONE;
                  end else begin
                     idx             <= idx + IDX_W'(1);
                     ena_write       <= 1'b1;
                     {oled_dc, data} <= entry(idx + IDX_W'(1));
                     state           <= SEND;
                  end
               end
            end
            DONE: state <= DONE;
            default: state <= RST_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_oled_init_ctrl.sv
// Directed bench for oled_init_ctrl: expected byte table plus reset, stall and mid-sequence reset runs.
module tb_oled_init_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       write_done;
   logic       oled_rst;
   logic       oled_dc;
   logic [7:0] data;
   logic       ena_write;
   logic       init_done;

   always #5 clk = ~clk;

   oled_init_ctrl #(
      .RST_LOW_CYCLES (1000),
      .RST_WAIT_CYCLES(1000)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .write_done(write_done),
      .oled_rst  (oled_rst),
      .oled_dc   (oled_dc),
      .data      (data),
      .ena_write (ena_write),
      .init_done (init_done)
   );

`ifdef OLED_INIT_CLEAR_EN
   localparam int N = 25 + 8 * 131;
`else
   localparam int N = 25;
`endif

   typedef struct {
      logic [7:0] exp_data;
      logic       exp_dc;
   } vec_t;

   vec_t vec [N];
   int   checks = 0;
   int   errors = 0;
   int   cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " oled_rst"},  {31'd0, oled_rst},  32'd0);
      check({tag, " oled_dc"},   {31'd0, oled_dc},   32'd0);
      check({tag, " data"},      {24'd0, data},      32'd0);
      check({tag, " ena_write"}, {31'd0, ena_write}, 32'd0);
      check({tag, " init_done"}, {31'd0, init_done}, 32'd0);
   endtask

   // Runs one power-up sequence; stall_k/stall_len hold write_done low in WAIT after pulse stall_k,
   // abort_k asserts reset on the cycle after pulse abort_k and returns.
   task automatic run(input int stall_k, input int stall_len, input int abort_k);
      int k = 0;
      int first_hi = -1;
      int done_cyc = -1;
      int stall_start = -1;
      int exp_cyc;
      int exp_done;
      bit rst_fell = 0;
      bit done_fell = 0;
      bit hold_bad = 0;
      write_done = 1'b1;
      rst_n = 1'b1;
      repeat (3) tick();
      check_reset_vals("reset");
      rst_n = 1'b0;
      cyc = 0;
      exp_done = 2001 + 3 * N + ((stall_k >= 0) ? stall_len : 0);
      while (cyc < exp_done + 20) begin
         tick();
         if (oled_rst === 1'b1 && first_hi < 0) first_hi = cyc;
         if (oled_rst !== 1'b1 && first_hi >= 0) rst_fell = 1;
         if (ena_write === 1'b1) begin
            if (k < N) begin
               exp_cyc = 2001 + 3 * k + ((stall_k >= 0 && k > stall_k) ? stall_len : 0);
               check($sformatf("pulse%0d cycle", k), cyc, exp_cyc);
               check($sformatf("pulse%0d data", k), {24'd0, data}, {24'd0, vec[k].exp_data});
               check($sformatf("pulse%0d dc", k), {31'd0, oled_dc}, {31'd0, vec[k].exp_dc});
            end else begin
               check("extra pulse", k, N - 1);
            end
            if (k == stall_k) stall_start = cyc + 2;
            if (k == abort_k) begin
               rst_n = 1'b1;
               tick();
               check_reset_vals("abort");
               return;
            end
            k++;
         end else if (k > 0 && k <= N) begin
            if (data !== vec[k-1].exp_data || oled_dc !== vec[k-1].exp_dc) hold_bad = 1;
         end
         if (init_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
         if (init_done !== 1'b1 && done_cyc >= 0) done_fell = 1;
         write_done = !(stall_start >= 0 && cyc >= stall_start && cyc < stall_start + stall_len);
      end
      check("oled_rst rise cycle", first_hi, 1001);
      check("oled_rst stays high", {31'd0, rst_fell}, 32'd0);
      check("pulse count", k, N);
      check("init_done rise cycle", done_cyc, exp_done);
      check("init_done sticky", {31'd0, done_fell}, 32'd0);
      check("data/dc hold", {31'd0, hold_bad}, 32'd0);
   endtask

   initial begin
      logic [7:0] cmd [25];
      cmd = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
              8'h14, 8'h20, 8'h02, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
              8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
      for (int i = 0; i < 25; i++) vec[i] = '{cmd[i], 1'b0};
`ifdef OLED_INIT_CLEAR_EN
      for (int p = 0; p < 8; p++) begin
         vec[25 + p*131 + 0] = '{8'hB0 + 8'(p), 1'b0};
         vec[25 + p*131 + 1] = '{8'h00, 1'b0};
         vec[25 + p*131 + 2] = '{8'h10, 1'b0};
         for (int o = 3; o < 131; o++) vec[25 + p*131 + o] = '{8'h00, 1'b1};
      end
`endif
      rst_n = 1'b1;
      write_done = 1'b1;
      cyc = 0;

      run(-1, 0, -1);
      run(2, 10, -1);
      run(-1, 0, 12);
      run(-1, 0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
